pipelined_approx_adder: RTL

//  Parametrised pipelined adder: BITWIDTH split into SEG_WIDTH ripple segments, one register stage per segment.

---
 rtl/approx_arith_pkg.sv | 25 ++
 rtl/rca_segment.sv | 23 ++
 rtl/pipelined_approx_adder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/approx_arith_pkg.sv
// Shared arithmetic helpers and mode encoding for the approximate adder datapath.
package approx_arith_pkg;

  typedef enum logic {
    ADD_EXACT = 1'b0,
    ADD_LOA   = 1'b1
  } adder_mode_e;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned calc_stages(input int unsigned bw, input int unsigned sw);
    return ceil_div(bw, sw);
  endfunction

  // Width of segment s; the top segment takes whatever bits remain.
  function automatic int unsigned seg_width(input int unsigned bw, input int unsigned sw,
                                            input int unsigned s);
    int unsigned rem;
    rem = bw - s * sw;
    return (rem < sw) ? rem : sw;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational W-bit ripple-carry segment built from full-adder cells.
module rca_segment #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_approx_adder.sv
// Segmented pipelined adder with per-transaction exact / lower-part-OR mode.
// Optional error monitor enabled by defining APPROX_ADDER_ERRMON_EN.
module pipelined_approx_adder
  import approx_arith_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 16,
  parameter int unsigned SEG_WIDTH   = 4,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITWIDTH-1:0]        a,
  input  logic [BITWIDTH-1:0]        b,
  input  logic                       cin,
  input  logic                       approx_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITWIDTH:0]          sum,
  output logic                       out_approx
`ifdef APPROX_ADDER_ERRMON_EN
  ,
  output logic signed [BITWIDTH+1:0] err_dist,
  output logic [31:0]                err_cnt
`endif
);

  localparam int unsigned STAGES = calc_stages(BITWIDTH, SEG_WIDTH);
  localparam int unsigned OPS    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned K      = APPROX_BITS;

  logic adv;
  logic take;

  logic [BITWIDTH-1:0] a_eff, b_eff, or_low;
  logic                cin_eff;

  logic [STAGES-1:0]               st_v, st_m, st_c, nxt_v, nxt_m, nxt_c;
  logic [STAGES-1:0][BITWIDTH-1:0] st_s, nxt_s;
  logic [OPS-1:0][BITWIDTH-1:0]    op_a, op_b, nxt_a, nxt_b;
  logic                            unused_ops;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;
  assign take     = in_valid & in_ready;

  // LOA: low bits become a|b (merged back at the end); bit K-1 of both operands carries
  // a[K-1]&b[K-1] so the ripple chain sees exactly that carry into bit K.
  if (K > 0) begin : g_loa
    localparam logic [BITWIDTH-1:0] LOW_MASK = ~({BITWIDTH{1'b1}} << K);
    logic g;
    always_comb begin
      g       = a[K-1] & b[K-1];
      a_eff   = a;
      b_eff   = b;
      cin_eff = cin;
      or_low  = '0;
      if (adder_mode_e'(approx_mode) == ADD_LOA) begin
        a_eff   = (a & ~LOW_MASK) | (BITWIDTH'(g) << (K - 1));
        b_eff   = (b & ~LOW_MASK) | (BITWIDTH'(g) << (K - 1));
        cin_eff = 1'b0;
        or_low  = (a | b) & LOW_MASK;
      end
    end
  end else begin : g_exact
    assign a_eff   = a;
    assign b_eff   = b;
    assign cin_eff = cin;
    assign or_low  = '0;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * SEG_WIDTH;
    localparam int unsigned W  = seg_width(BITWIDTH, SEG_WIDTH, s);
    logic [W-1:0] sa, sb, ss;
    logic         sc, co;

    if (s == 0) begin : g_first
      assign sa       = a_eff[LO +: W];
      assign sb       = b_eff[LO +: W];
      assign sc       = cin_eff;
      assign nxt_s[s] = or_low | (BITWIDTH'(ss) << LO);
      assign nxt_v[s] = take;
      assign nxt_m[s] = approx_mode;
      if (STAGES > 1) begin : g_fwd
        assign nxt_a[s] = a_eff;
        assign nxt_b[s] = b_eff;
      end
    end else begin : g_next
      assign sa       = op_a[s-1][LO +: W];
      assign sb       = op_b[s-1][LO +: W];
      assign sc       = st_c[s-1];
      assign nxt_s[s] = st_s[s-1] | (BITWIDTH'(ss) << LO);
      assign nxt_v[s] = st_v[s-1];
      assign nxt_m[s] = st_m[s-1];
      if (s < STAGES - 1) begin : g_fwd
        assign nxt_a[s] = op_a[s-1];
        assign nxt_b[s] = op_b[s-1];
      end
    end

    rca_segment #(.W(W)) u_rca (
      .a    (sa),
      .b    (sb),
      .cin  (sc),
      .s    (ss),
      .cout (co)
    );

    assign nxt_c[s] = co;
  end

  if (STAGES == 1) begin : g_no_fwd
    assign nxt_a = '0;
    assign nxt_b = '0;
  end

  // Operand skew registers: each stage only consumes its own slice of what it forwards.
  assign unused_ops = ^{op_a, op_b};

  // Whole pipeline shifts together on adv; bubbles travel with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v <= '0;
      st_m <= '0;
      st_c <= '0;
      st_s <= '0;
      op_a <= '0;
      op_b <= '0;
    end else if (adv) begin
      st_v <= nxt_v;
      st_m <= nxt_m;
      st_c <= nxt_c;
      st_s <= nxt_s;
      op_a <= nxt_a;
      op_b <= nxt_b;
    end
  end

  assign out_valid  = st_v[STAGES-1];
  assign out_approx = st_m[STAGES-1];
  assign sum        = {st_c[STAGES-1], st_s[STAGES-1]};

`ifdef APPROX_ADDER_ERRMON_EN
  logic [STAGES-1:0][BITWIDTH:0] ex_pipe;
  logic [BITWIDTH:0]             ex_in;

  assign ex_in = (BITWIDTH+1)'(a) + (BITWIDTH+1)'(b) + (BITWIDTH+1)'(cin);

  // Shadow exact result, aligned with the main pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pipe <= '0;
    end else if (adv) begin
      ex_pipe[0] <= ex_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        ex_pipe[i] <= ex_pipe[i-1];
      end
    end
  end

  assign err_dist = $signed({1'b0, ex_pipe[STAGES-1]}) - $signed({1'b0, sum});

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && (err_dist != '0) && (err_cnt != 32'hFFFF_FFFF)) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

endmodule
